// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings and read-arbiter FSM states
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or above ptr, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;

  // Rotate so bit 0 is the requester at ptr, take the lowest set bit, map back to an absolute index
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    sum   = '0;
    valid = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum   = {1'b0, ptr} + (IDX_W + 1)'(j);
        valid = 1'b1;
      end
    end
    if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
      sum = sum - (IDX_W + 1)'(NUM_REQ);
    end
    idx = sum[IDX_W-1:0];
    gnt = valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin AR/R arbiter for one AXI slave; AXI_RD_ARB_LEN_CHECK_EN adds LEN_ERR
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [NUM_MASTERS*8-1:0]              S_AXI_ARLEN,
  input  logic [NUM_MASTERS*3-1:0]              S_AXI_ARSIZE,
  input  logic [NUM_MASTERS*2-1:0]              S_AXI_ARBURST,
  input  logic [NUM_MASTERS-1:0]                S_AXI_ARVALID,
  output logic [NUM_MASTERS-1:0]                S_AXI_ARREADY,
  output logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [NUM_MASTERS*2-1:0]              S_AXI_RRESP,
  output logic [NUM_MASTERS-1:0]                S_AXI_RLAST,
  output logic [NUM_MASTERS-1:0]                S_AXI_RVALID,
  input  logic [NUM_MASTERS-1:0]                S_AXI_RREADY,
  output logic [AXI_ID_WIDTH-1:0]               M_AXI_ARID,
  output logic [AXI_ADDR_WIDTH-1:0]             M_AXI_ARADDR,
  output logic [7:0]                            M_AXI_ARLEN,
  output logic [2:0]                            M_AXI_ARSIZE,
  output logic [1:0]                            M_AXI_ARBURST,
  output logic                                  M_AXI_ARVALID,
  input  logic                                  M_AXI_ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]               M_AXI_RID,
  input  logic [AXI_DATA_WIDTH-1:0]             M_AXI_RDATA,
  input  logic [1:0]                            M_AXI_RRESP,
  input  logic                                  M_AXI_RLAST,
  input  logic                                  M_AXI_RVALID,
  output logic                                  M_AXI_RREADY,
  output logic [NUM_MASTERS-1:0]                GRANT
`ifdef AXI_RD_ARB_LEN_CHECK_EN
  ,
  output logic                                  LEN_ERR
`endif
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e             state, state_nxt;
  logic [IW-1:0]          g_idx, ptr, arb_idx;
  logic [NUM_MASTERS-1:0] grant, arb_gnt;
  logic                   arb_valid;
  logic                   ar_hs, r_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IW)
  ) u_rr (
    .req   (S_AXI_ARVALID),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign ar_hs = (state == ADDR) && S_AXI_ARVALID[g_idx] && M_AXI_ARREADY;
  assign r_hs  = (state == DATA) && M_AXI_RVALID && S_AXI_RREADY[g_idx];

  // AR payload always follows the registered grant; ARVALID alone is gated by state
  assign M_AXI_ARID    = S_AXI_ARID[g_idx*AXI_ID_WIDTH +: AXI_ID_WIDTH];
  assign M_AXI_ARADDR  = S_AXI_ARADDR[g_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
  assign M_AXI_ARLEN   = S_AXI_ARLEN[g_idx*8 +: 8];
  assign M_AXI_ARSIZE  = S_AXI_ARSIZE[g_idx*3 +: 3];
  assign M_AXI_ARBURST = S_AXI_ARBURST[g_idx*2 +: 2];

  // R payload is broadcast; only RVALID is steered to the owner
  assign S_AXI_RID   = {NUM_MASTERS{M_AXI_RID}};
  assign S_AXI_RDATA = {NUM_MASTERS{M_AXI_RDATA}};
  assign S_AXI_RRESP = {NUM_MASTERS{M_AXI_RRESP}};
  assign S_AXI_RLAST = {NUM_MASTERS{M_AXI_RLAST}};

  assign GRANT = grant;

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and channel steering for the granted master
  always_comb begin
    state_nxt     = state;
    M_AXI_ARVALID = 1'b0;
    S_AXI_ARREADY = '0;
    S_AXI_RVALID  = '0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) state_nxt = ADDR;
      end
      ADDR: begin
        M_AXI_ARVALID = S_AXI_ARVALID[g_idx];
        S_AXI_ARREADY = M_AXI_ARREADY ? grant : '0;
        if (ar_hs) state_nxt = DATA;
      end
      DATA: begin
        S_AXI_RVALID = M_AXI_RVALID ? grant : '0;
        M_AXI_RREADY = S_AXI_RREADY[g_idx];
        if (r_hs && M_AXI_RLAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture winner and advance the rotation pointer in IDLE; drop the grant on the RLAST handshake
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      grant <= '0;
      g_idx <= '0;
      ptr   <= '0;
    end else if (state == IDLE && arb_valid) begin
      grant <= arb_gnt;
      g_idx <= arb_idx;
      ptr   <= (arb_idx == IW'(NUM_MASTERS - 1)) ? '0 : arb_idx + IW'(1);
    end else if (r_hs && M_AXI_RLAST) begin
      grant <= '0;
    end
  end

`ifdef AXI_RD_ARB_LEN_CHECK_EN
  logic [7:0] arlen_q, beat;
  logic       len_err;

  // Beat counter against latched ARLEN; RLAST must coincide exactly with beat ARLEN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arlen_q <= '0;
      beat    <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (ar_hs) begin
        arlen_q <= M_AXI_ARLEN;
        beat    <= '0;
      end else if (r_hs) begin
        beat <= beat + 8'd1;
        if (M_AXI_RLAST != (beat == arlen_q)) len_err <= 1'b1;
      end
    end
  end

  assign LEN_ERR = len_err;
`endif

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the read channels (AR and R) of one downstream AXI slave among NUM_MASTERS upstream AXI masters.
- Arbitration is round-robin. A grant is held from AR acceptance through the RLAST handshake.
- Sits between master-side ports and the M_AXI_* read side of axi_crossbar or axi_slave.
- Write channels are out of scope; a separate write arbiter handles them.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
AXI_ID_WIDTH, 1, ID width, passed through unchanged
AXI_DATA_WIDTH, 32, R data width
AXI_ADDR_WIDTH, 32, AR address width

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous, active-high reset
S_AXI_ARID  in  NUM_MASTERS*AXI_ID_WIDTH  per-master ARID; master i in slice i
S_AXI_ARADDR  in  NUM_MASTERS*AXI_ADDR_WIDTH  per-master ARADDR
S_AXI_ARLEN  in  NUM_MASTERS*8  per-master ARLEN
S_AXI_ARSIZE  in  NUM_MASTERS*3  per-master ARSIZE
S_AXI_ARBURST  in  NUM_MASTERS*2  per-master ARBURST
S_AXI_ARVALID  in  NUM_MASTERS  per-master ARVALID
S_AXI_ARREADY  out  NUM_MASTERS  per-master ARREADY
S_AXI_RID  out  NUM_MASTERS*AXI_ID_WIDTH  broadcast RID
S_AXI_RDATA  out  NUM_MASTERS*AXI_DATA_WIDTH  broadcast RDATA
S_AXI_RRESP  out  NUM_MASTERS*2  broadcast RRESP
S_AXI_RLAST  out  NUM_MASTERS  broadcast RLAST
S_AXI_RVALID  out  NUM_MASTERS  one-hot-or-zero RVALID
S_AXI_RREADY  in  NUM_MASTERS  per-master RREADY
M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  widths as single master  muxed AR payload
M_AXI_ARVALID  out  1  AR valid to slave
M_AXI_ARREADY  in  1  AR ready from slave
M_AXI_RID/RDATA/RRESP/RLAST  in  single-master widths  R payload from slave
M_AXI_RVALID  in  1  R valid from slave
M_AXI_RREADY  out  1  R ready to slave
GRANT  out  NUM_MASTERS  one-hot current grant (debug/perf)

Behaviour:
- Clock and reset: one clock, ACLK. Reset ARESET is synchronous and active-high.
- Reset state:
  - FSM in IDLE; grant 0; rr pointer 0.
  - All outputs 0: M_AXI_ARVALID, M_AXI_RREADY, S_AXI_ARREADY, S_AXI_RVALID, GRANT.
  - Reset asserted mid-burst abandons the transaction; no outputs are kept.
- FSM IDLE:
  - If any S_AXI_ARVALID is set, register a winner, set GRANT, go to ADDR.
  - Winner is the first requester at or above index ptr, wrapping modulo NUM_MASTERS.
  - ptr <= winner+1, wrapping.
- FSM ADDR:
  - M_AXI_AR* = granted slice; M_AXI_ARVALID = granted S_AXI_ARVALID.
  - S_AXI_ARREADY[g] = M_AXI_ARREADY; all other bits 0.
  - On AR handshake go to DATA.
- FSM DATA:
  - S_AXI_RVALID[g] = M_AXI_RVALID; others 0.
  - M_AXI_RREADY = S_AXI_RREADY[g].
  - On a handshake with M_AXI_RLAST=1: clear GRANT, go to IDLE.
- Latency:
  - ARVALID to M_AXI_ARVALID is 1 cycle.
  - R path is combinational, 0 cycles.
  - One IDLE cycle separates consecutive bursts.
- Payload broadcast: R payload goes to all masters; only RVALID is qualified.
- Grant hold: no re-arbitration while in ADDR/DATA. Requests from other masters wait; AXI requires VALID to stay high, so none is lost.
- Valid drop: if the granted master drops ARVALID in ADDR (protocol violation), the FSM stays in ADDR. No timeout.
- Boundaries:
  - ARLEN=0: single beat with RLAST.
  - ARLEN=255: 256 beats; no internal counter overflow.
  - Simultaneous requests from all masters: strict rotation, so each master is served once per NUM_MASTERS grants.
- No outstanding transactions: one burst in flight at a time.

Optional Feature:
AXI_RD_ARB_LEN_CHECK_EN
- Defined:
  - Latch granted ARLEN on AR handshake; an 8-bit beat counter counts R handshakes.
  - Adds output LEN_ERR (1 bit, reset 0).
  - LEN_ERR pulses 1 cycle when RLAST arrives at beat != ARLEN, or beat ARLEN completes without RLAST.
  - The grant still releases only on RLAST.
- Undefined: no counter and no LEN_ERR port.

Decomposition:
- Shared package axi_pkg: burst encodings (FIXED=2'b00, INCR=2'b01, WRAP=2'b10), RRESP OKAY=2'b00, FSM state encodings (IDLE, ADDR, DATA).
- One sub-module: rr_arbiter (request vector, ptr in; one-hot grant, index out; purely combinational).
- Reuse rr_arbiter in the future write arbiter.

Test Plan:
- Single master 0 reads addr 0x40, ARLEN=31, INCR:
  - M_AXI_ARADDR=0x40 one cycle after ARVALID.
  - 32 beats reach master 0 only; GRANT returns to 0 after RLAST.
- Masters 0 and 1 assert ARVALID in the same cycle, ptr=0:
  - Master 0 is served first, master 1 next.
  - Repeat from ptr=1: master 1 is served first.
- Master 1 drops RREADY for 3 cycles mid-burst:
  - M_AXI_RREADY=0 for those cycles; no beats lost; data order intact.
- Master 0 requests during master 1's burst:
  - M_AXI_ARVALID stays low until master 1's RLAST handshake.
  - Then exactly one IDLE cycle, then master 0's AR appears.
- ARESET asserted at beat 5 of an ARLEN=15 burst: next cycle all outputs are 0, FSM is IDLE, ptr is 0.
- With LEN_CHECK_EN, slave gives RLAST at beat 3 of ARLEN=7: LEN_ERR=1 for exactly one cycle and the grant releases.
